// File: rtl/uart8_echo.sv
// Byte-echo responder for a Uart8: buffers each received byte in a FIFO and
// replays the bytes in arrival order through the Uart8 transmit handshake.
module uart8_echo #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter bit DROP_ERR        = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     rxDone,
  input  logic                     rxErr,
  input  logic [7:0]               rxByte,
  input  logic                     txBusy,
  input  logic                     txDone,
  output logic                     txEn,
  output logic                     txStart,
  output logic [7:0]               txByte,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     overflow,
  output logic [7:0]               errCount,
  output logic [1:0]               dbgState
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]                 state;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wrPtr;
  logic [FIFO_DEPTH_LOG2-1:0] rdPtr;

  // rx inputs are sampled first; the edge is judged against the previous sample
  logic       rxDoneSmp;
  logic       rxErrSmp;
  logic [7:0] rxByteSmp;
  logic       rxDonePrev;
  logic       txDonePrev;

  logic rxRise;
  logic txRise;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic accept;

  assign dbgState = state;
  assign rxRise   = rxDoneSmp & ~rxDonePrev;
  assign txRise   = txDone & ~txDonePrev;
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  // txEn is the copy of en taken on the same edge that sampled rxDone
  assign push     = txEn & rxRise & ~(DROP_ERR & rxErrSmp);
  assign pop      = (state == IDLE) & en & ~empty & ~txBusy;
  // a push into a full FIFO survives only when a pop frees the slot this cycle
  assign accept   = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wrPtr] <= rxByteSmp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxDoneSmp  <= 1'b0;
      rxErrSmp   <= 1'b0;
      rxByteSmp  <= 8'h00;
      rxDonePrev <= 1'b0;
      txDonePrev <= 1'b0;
      txEn       <= 1'b0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      errCount   <= 8'h00;
    end else begin
      rxDoneSmp  <= rxDone;
      rxErrSmp   <= rxErr;
      rxByteSmp  <= rxByte;
      rxDonePrev <= rxDoneSmp;
      txDonePrev <= txDone;
      txEn       <= en;
      if (accept) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push & full & ~pop) begin
        overflow <= 1'b1;
      end
      if (rxRise & rxErrSmp & (errCount != 8'hFF)) begin
        errCount <= errCount + 8'd1;
      end
    end
  end

  // Handshake: txStart/txByte are held until txBusy is seen high (the
  // transmitter has taken the byte); txDone rising then frees the launcher.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      txStart <= 1'b0;
      txByte  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            txByte  <= mem[rdPtr];
            txStart <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (txBusy) begin
            txStart <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (txRise) begin
            state <= IDLE;
          end
        end
        default: begin
          txStart <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
